// File: rtl/lc_pkg.sv
// Shared constants, state encoding and header helper for the line compressor.
package lc_pkg;

  localparam int BEAT_W = 256;
  localparam int BUF_W  = 2 * BEAT_W;

  // Per-word size codes, smallest representation first
  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_B8   = 2'b01;
  localparam logic [1:0] CODE_B16  = 2'b10;
  localparam logic [1:0] CODE_B32  = 2'b11;

  // Header beat field positions
  localparam int HDR_BITMAP_LSB = 0;
  localparam int HDR_BITS_LSB   = 16;
  localparam int HDR_NEED_BIT   = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DRAIN,
    ST_FLUSH
  } state_t;

  function automatic logic [BEAT_W-1:0] make_header(input logic [15:0] bitmap,
                                                    input logic [8:0]  bits,
                                                    input logic        need);
    logic [BEAT_W-1:0] h;
    h = '0;
    h[HDR_BITMAP_LSB +: 16] = bitmap;
    h[HDR_BITS_LSB +: 9]    = bits;
    h[HDR_NEED_BIT]         = need;
    return h;
  endfunction

endpackage

// File: rtl/lc_word_classify.sv
// Picks the narrowest sign-extended width (0/8/16/32 bits) that represents one word.
module lc_word_classify
  import lc_pkg::*;
(
  input  logic [31:0] word,
  output logic [1:0]  code,
  output logic [5:0]  len
);

  logic fits8;
  logic fits16;

  // A word fits N bits when everything from bit N-1 upward is a copy of the sign
  assign fits8  = (&word[31:7])  | ~(|word[31:7]);
  assign fits16 = (&word[31:15]) | ~(|word[31:15]);

  // Smallest matching code wins
  always_comb begin
    code = CODE_B32;
    len  = 6'd32;
    if (word == 32'd0) begin
      code = CODE_ZERO;
      len  = 6'd0;
    end else if (fits8) begin
      code = CODE_B8;
      len  = 6'd8;
    end else if (fits16) begin
      code = CODE_B16;
      len  = 6'd16;
    end
  end

endmodule

// File: rtl/line_compressor.sv
// Line compressor: classifies each 256-bit line word-by-word, emits a header beat,
// and packs the variable-length payloads into 256-bit data beats.
// Optional build macro LINE_COMPRESSOR_STATS_EN adds stat_lines / stat_bits counters.
module line_compressor
  import lc_pkg::*;
#(
  parameter int THRESH_BITS = 224
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_is_header
`ifdef LINE_COMPRESSOR_STATS_EN
  ,
  output logic [31:0]       stat_lines,
  output logic [31:0]       stat_bits
`endif
);

  logic [1:0]        code [8];
  logic [5:0]        len  [8];

  logic [31:0]       w;
  logic [31:0]       wm;
  logic [8:0]        off;
  logic [15:0]       bm;
  logic [BEAT_W-1:0] pk;

  logic [15:0]       cls_bm;
  logic [8:0]        cls_bits;
  logic              cls_need;
  logic [BEAT_W-1:0] cls_payload;

  state_t            state_q, next_state;
  logic              rdy_en_q;
  logic [15:0]       bm_q;
  logic [8:0]        bits_q;
  logic              need_q;
  logic [BEAT_W-1:0] payload_q;
  logic              last_q;
  logic [BUF_W-1:0]  buf_q;
  logic [9:0]        fill_q;

  logic              hs_in;
  logic              hs_out;
  logic [9:0]        fill_after_hdr;
  logic [BEAT_W-1:0] flush_data;

  for (genvar g = 0; g < 8; g++) begin : g_cls
    lc_word_classify u_cls (
      .word (in_data[32*g +: 32]),
      .code (code[g]),
      .len  (len[g])
    );
  end

  // Pack the kept low bits of each word LSB-first and apply the raw fallback
  always_comb begin
    w   = '0;
    wm  = '0;
    off = '0;
    bm  = '0;
    pk  = '0;
    for (int i = 0; i < 8; i++) begin
      w = in_data[32*i +: 32];
      case (code[i])
        CODE_ZERO: wm = '0;
        CODE_B8:   wm = {24'b0, w[7:0]};
        CODE_B16:  wm = {16'b0, w[15:0]};
        default:   wm = w;
      endcase
      pk  = pk | ({224'b0, wm} << off);
      off = off + {3'b0, len[i]};
      bm[2*i +: 2] = code[i];
    end
    if (int'(off) > THRESH_BITS) begin
      cls_bm      = 16'hFFFF;
      cls_bits    = 9'd256;
      cls_need    = 1'b0;
      cls_payload = in_data;
    end else begin
      cls_bm      = bm;
      cls_bits    = off;
      cls_need    = (bm != 16'hFFFF);
      cls_payload = pk;
    end
  end

  assign hs_in          = in_valid & in_ready;
  assign hs_out         = out_valid & out_ready;
  assign fill_after_hdr = fill_q + {1'b0, bits_q};
  assign flush_data     = buf_q[BEAT_W-1:0] & ((256'b1 << fill_q) - 256'b1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= next_state;
  end

  // Next-state and output decode
  always_comb begin
    next_state    = state_q;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_is_header = 1'b0;
    out_data      = '0;
    case (state_q)
      ST_IDLE: begin
        in_ready = rdy_en_q && (fill_q < 10'd256);
        if (in_valid && rdy_en_q && (fill_q < 10'd256)) next_state = ST_HDR;
      end
      ST_HDR: begin
        out_valid     = 1'b1;
        out_is_header = 1'b1;
        out_data      = make_header(bm_q, bits_q, need_q);
        if (out_ready) begin
          if (fill_after_hdr >= 10'd256) next_state = ST_DRAIN;
          else if (last_q)               next_state = ST_FLUSH;
          else                           next_state = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_data  = buf_q[BEAT_W-1:0];
        if (out_ready) begin
          if (((fill_q - 10'd256) < 10'd256) && last_q) next_state = ST_FLUSH;
          else                                          next_state = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        out_valid = (fill_q != 10'd0);
        out_data  = (fill_q != 10'd0) ? flush_data : '0;
        if ((fill_q == 10'd0) || out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Line capture, pack buffer append / shift / flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q  <= 1'b0;
      bm_q      <= '0;
      bits_q    <= '0;
      need_q    <= 1'b0;
      payload_q <= '0;
      last_q    <= 1'b0;
      buf_q     <= '0;
      fill_q    <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (hs_in) begin
        bm_q      <= cls_bm;
        bits_q    <= cls_bits;
        need_q    <= cls_need;
        payload_q <= cls_payload;
        last_q    <= in_last;
      end
      case (state_q)
        ST_HDR: if (hs_out) begin
          buf_q  <= buf_q | ({256'b0, payload_q} << fill_q);
          fill_q <= fill_after_hdr;
        end
        ST_DRAIN: if (hs_out) begin
          buf_q  <= {256'b0, buf_q[BUF_W-1:BEAT_W]};
          fill_q <= fill_q - 10'd256;
        end
        ST_FLUSH: if ((fill_q == 10'd0) || hs_out) begin
          buf_q  <= '0;
          fill_q <= '0;
          last_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef LINE_COMPRESSOR_STATS_EN
  // Accepted-line and header-payload-bit counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lines <= '0;
      stat_bits  <= '0;
    end else begin
      if (hs_in) stat_lines <= stat_lines + 32'd1;
      if ((state_q == ST_HDR) && hs_out) stat_bits <= stat_bits + {23'b0, bits_q};
    end
  end
`endif

endmodule
